// File: rtl/vt_seq_detect_pkg.sv
// ============================================================================
// Module   : vt_seq_detect_pkg
// Purpose  : Shared mode encodings and helpers for the parametrised
//            serial bit-pattern detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vt_seq_detect_pkg;

  // Runtime detection modes
  typedef enum logic [1:0] {
    MODE_FRAMED     = 2'd0,
    MODE_SLIDE_NOVL = 2'd1,
    MODE_SLIDE_OVL  = 2'd2
  } mode_e;

  // Encoding 3 is not a distinct mode; it behaves as sliding-overlap
  function automatic mode_e map_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'd0:    m = MODE_FRAMED;
      2'd1:    m = MODE_SLIDE_NOVL;
      default: m = MODE_SLIDE_OVL;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vt_seq_detect_param_if.sv
// ============================================================================
// Module   : vt_seq_detect_param_if
// Purpose  : Serial-input / match-report bundle for vt_seq_detect_param.
//            master = bit source / result consumer, slave = detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vt_seq_detect_param_if #(
  parameter int CNT_W = 8
);
  logic             i_en;
  logic             i_SI;
  logic [1:0]       i_mode;
  logic             i_clr_cnt;
  logic             o_f;
  logic [CNT_W-1:0] o_match_cnt;
  logic             o_cnt_sat;

  modport master (
    output i_en, i_SI, i_mode, i_clr_cnt,
    input  o_f, o_match_cnt, o_cnt_sat
  );

  modport slave (
    input  i_en, i_SI, i_mode, i_clr_cnt,
    output o_f, o_match_cnt, o_cnt_sat
  );
endinterface

`default_nettype wire

// File: rtl/vt_sat_counter.sv
// ============================================================================
// Module   : vt_sat_counter
// Purpose  : Saturating up-counter with synchronous clear (clear wins over
//            increment) and a registered all-ones flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vt_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next count: clear has priority, increments stop at all-ones
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && !(&r_cnt)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Count and saturation flag are both taken from the next value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= &w_cnt_nxt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = r_sat;

endmodule

`default_nettype wire

// File: rtl/vt_seq_detect_param.sv
// ============================================================================
// Module   : vt_seq_detect_param
// Purpose  : Parametrised serial pattern detector with framed, sliding
//            non-overlapping and sliding overlapping modes, a bit-valid
//            qualifier and a saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vt_seq_detect_param
  import vt_seq_detect_pkg::*;
#(
  parameter int                 SEQ_LEN = 6,
  parameter logic [SEQ_LEN-1:0] PATTERN = 6'b100110,
  parameter int                 CNT_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  vt_seq_detect_param_if.slave  bus
);

  localparam int           C_PW   = $clog2(SEQ_LEN);
  localparam logic [C_PW-1:0] C_LAST = C_PW'(SEQ_LEN - 1);

  // Only the last SEQ_LEN-1 bits are kept; the live input completes the window
  logic [SEQ_LEN-2:0] r_hist;
  logic [C_PW-1:0]    r_fill;
  logic [C_PW-1:0]    r_frame;
  mode_e              r_mode;

  mode_e              w_mode;
  logic               w_mode_chg;
  logic [SEQ_LEN-1:0] w_win;
  logic               w_armed;
  logic               w_hit;

  assign w_mode     = map_mode(bus.i_mode);
  assign w_mode_chg = (w_mode != r_mode);
  assign w_win      = {r_hist, bus.i_SI};

  // Enough aligned/fresh bits have been seen for the window to be judged
  assign w_armed = (r_mode == MODE_FRAMED) ? (r_frame == C_LAST)
                                           : (r_fill  == C_LAST);

  // Mealy match: suppressed in the cycle a mode change is seen
  assign w_hit = bus.i_en && !w_mode_chg && w_armed && (w_win == PATTERN);
  assign bus.o_f = w_hit;

  // Registered mode follows the (mapped) input every cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= MODE_FRAMED;
    end else begin
      r_mode <= w_mode;
    end
  end

  // History shifts on every valid bit, even across a mode change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= '0;
    end else if (bus.i_en) begin
      r_hist <= w_win[SEQ_LEN-2:0];
    end
  end

  // Frame and fill counters; a mode change restarts both so stale history is not trusted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill  <= '0;
      r_frame <= '0;
    end else if (w_mode_chg) begin
      r_fill  <= '0;
      r_frame <= '0;
    end else if (bus.i_en) begin
      r_frame <= (r_frame == C_LAST) ? '0 : r_frame + 1'b1;
      if ((r_mode == MODE_SLIDE_NOVL) && w_hit) begin
        r_fill <= '0;
      end else if (r_fill != C_LAST) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  vt_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_hit),
    .i_clr   (bus.i_clr_cnt),
    .o_cnt   (bus.o_match_cnt),
    .o_sat   (bus.o_cnt_sat)
  );

endmodule

`default_nettype wire

// File: tb/tb_vt_seq_detect_param.sv
// ============================================================================
// Module   : tb_vt_seq_detect_param
// Purpose  : Self-checking bench for vt_seq_detect_param. Two instances
//            (CNT_W=8 and CNT_W=2) receive identical stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vt_seq_detect_param;

  localparam int         SEQ_LEN = 6;
  localparam logic [5:0] PATTERN = 6'b100110;
  localparam int         MAX_A   = 255;
  localparam int         MAX_B   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vt_seq_detect_param_if #(.CNT_W(8)) bus_a ();
  vt_seq_detect_param_if #(.CNT_W(2)) bus_b ();

  vt_seq_detect_param #(.SEQ_LEN(SEQ_LEN), .PATTERN(PATTERN), .CNT_W(8)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_a)
  );

  vt_seq_detect_param #(.SEQ_LEN(SEQ_LEN), .PATTERN(PATTERN), .CNT_W(2)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bits consumed since reset / last mode change
  bit q[$];
  int last_end;
  int mdl_mode;
  int cnt_a;
  int cnt_b;

  task automatic model_reset();
    q.delete();
    last_end = 0;
    mdl_mode = 0;
    cnt_a    = 0;
    cnt_b    = 0;
  endtask

  task automatic drive(input bit en, input bit si, input logic [1:0] mode, input bit clr);
    bus_a.i_en = en; bus_a.i_SI = si; bus_a.i_mode = mode; bus_a.i_clr_cnt = clr;
    bus_b.i_en = en; bus_b.i_SI = si; bus_b.i_mode = mode; bus_b.i_clr_cnt = clr;
  endtask

  // One clock of stimulus, checked against the model before the edge
  task automatic step(input bit en, input bit si, input logic [1:0] mode, input bit clr,
                      output bit f_obs);
    int m, n;
    bit chg, cond, win_ok, exp_f;
    logic [SEQ_LEN-1:0] w;
    @(negedge clk);
    drive(en, si, mode, clr);
    #1;
    m   = (mode == 2'd3) ? 2 : int'(mode);
    chg = (m != mdl_mode);
    n   = q.size() + 1;
    case (m)
      0:       cond = ((n % SEQ_LEN) == 0);
      1:       cond = ((n - last_end) >= SEQ_LEN);
      default: cond = (n >= SEQ_LEN);
    endcase
    w      = '0;
    win_ok = 1'b0;
    if (q.size() >= SEQ_LEN - 1) begin
      for (int k = 0; k < SEQ_LEN - 1; k++)
        w[SEQ_LEN-1-k] = q[q.size() - (SEQ_LEN - 1) + k];
      w[0]   = si;
      win_ok = (w == PATTERN);
    end
    exp_f = en && !chg && cond && win_ok;

    checks++;
    if (bus_a.o_f !== exp_f) begin
      errors++; $display("FAIL o_f_a t=%0t got %b expected %b", $time, bus_a.o_f, exp_f);
    end
    checks++;
    if (bus_b.o_f !== exp_f) begin
      errors++; $display("FAIL o_f_b t=%0t got %b expected %b", $time, bus_b.o_f, exp_f);
    end
    checks++;
    if (bus_a.o_match_cnt !== 8'(cnt_a)) begin
      errors++; $display("FAIL cnt_a t=%0t got %0d expected %0d", $time, bus_a.o_match_cnt, cnt_a);
    end
    checks++;
    if (bus_b.o_match_cnt !== 2'(cnt_b)) begin
      errors++; $display("FAIL cnt_b t=%0t got %0d expected %0d", $time, bus_b.o_match_cnt, cnt_b);
    end
    checks++;
    if (bus_a.o_cnt_sat !== (cnt_a == MAX_A)) begin
      errors++; $display("FAIL sat_a t=%0t got %b expected %b", $time, bus_a.o_cnt_sat, cnt_a == MAX_A);
    end
    checks++;
    if (bus_b.o_cnt_sat !== (cnt_b == MAX_B)) begin
      errors++; $display("FAIL sat_b t=%0t got %b expected %b", $time, bus_b.o_cnt_sat, cnt_b == MAX_B);
    end
    f_obs = bus_a.o_f;

    if (chg) begin
      q.delete();
      last_end = 0;
    end else if (en) begin
      q.push_back(si);
      if (exp_f) last_end = q.size();
    end
    mdl_mode = m;
    if (clr) begin
      cnt_a = 0; cnt_b = 0;
    end else if (exp_f) begin
      if (cnt_a < MAX_A) cnt_a++;
      if (cnt_b < MAX_B) cnt_b++;
    end
  endtask

  task automatic idle(input logic [1:0] mode);
    bit f;
    step(1'b0, 1'b0, mode, 1'b0, f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Feed bits MSB-first; exp_pos bit i set means a pulse on bit i+1
  task automatic run_stream(input string name, input logic [31:0] bits, input int len,
                            input logic [1:0] mode, input logic [31:0] exp_pos);
    bit f;
    for (int i = 0; i < len; i++) begin
      step(1'b1, bits[len-1-i], mode, 1'b0, f);
      checks++;
      if (f !== exp_pos[i]) begin
        errors++;
        $display("FAIL %s bit %0d o_f got %b expected %b", name, i + 1, f, exp_pos[i]);
      end
    end
  endtask

  task automatic check_cnt(input string name, input int exp_a, input int exp_b, input bit exp_sb);
    checks++;
    if (bus_a.o_match_cnt !== 8'(exp_a)) begin
      errors++; $display("FAIL %s cnt_a got %0d expected %0d", name, bus_a.o_match_cnt, exp_a);
    end
    checks++;
    if (bus_b.o_match_cnt !== 2'(exp_b) || bus_b.o_cnt_sat !== exp_sb) begin
      errors++;
      $display("FAIL %s cnt_b/sat_b got %0d/%b expected %0d/%b", name,
               bus_b.o_match_cnt, bus_b.o_cnt_sat, exp_b, exp_sb);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 2'd0, 1'b0);
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus_a.o_f !== 1'b0 || bus_a.o_match_cnt !== 8'd0 || bus_a.o_cnt_sat !== 1'b0 ||
        bus_b.o_f !== 1'b0 || bus_b.o_match_cnt !== 2'd0 || bus_b.o_cnt_sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got f=%b cnt=%0d sat=%b expected 0/0/0",
               bus_a.o_f, bus_a.o_match_cnt, bus_a.o_cnt_sat);
    end
    do_reset();
  endtask

  task automatic test_framed();
    do_reset();
    idle(2'd0);
    run_stream("framed", 32'b100110100110, 12, 2'd0, (32'd1 << 5) | (32'd1 << 11));
    idle(2'd0);
    check_cnt("framed_cnt", 2, 2, 1'b0);
  endtask

  task automatic test_modes();
    do_reset(); idle(2'd2);
    run_stream("ovl", 32'b1001100110, 10, 2'd2, (32'd1 << 5) | (32'd1 << 9));
    idle(2'd2); check_cnt("ovl_cnt", 2, 2, 1'b0);
    do_reset(); idle(2'd1);
    run_stream("novl", 32'b1001100110, 10, 2'd1, 32'd1 << 5);
    idle(2'd1); check_cnt("novl_cnt", 1, 1, 1'b0);
    do_reset(); idle(2'd0);
    run_stream("frm10", 32'b1001100110, 10, 2'd0, 32'd1 << 5);
    idle(2'd0); check_cnt("frm10_cnt", 1, 1, 1'b0);
  endtask

  task automatic test_misalign();
    do_reset(); idle(2'd0);
    run_stream("mis_frm", 32'b0100110, 7, 2'd0, 32'd0);
    do_reset(); idle(2'd1);
    run_stream("mis_novl", 32'b0100110, 7, 2'd1, 32'd1 << 6);
  endtask

  task automatic test_gaps();
    logic [5:0] pat;
    bit f;
    pat = PATTERN;
    do_reset(); idle(2'd0);
    for (int i = 0; i < SEQ_LEN; i++) begin
      int gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'($urandom), 2'd0, 1'b0, f);
        checks++;
        if (f !== 1'b0) begin
          errors++; $display("FAIL gap o_f got %b expected 0", f);
        end
      end
      step(1'b1, pat[SEQ_LEN-1-i], 2'd0, 1'b0, f);
      checks++;
      if (f !== (i == SEQ_LEN - 1)) begin
        errors++; $display("FAIL gap_bit %0d o_f got %b expected %b", i + 1, f, i == SEQ_LEN - 1);
      end
    end
  endtask

  task automatic test_async_reset();
    bit f;
    do_reset(); idle(2'd0);
    run_stream("pre_rst", 32'b100110, 6, 2'd0, 32'd1 << 5);
    run_stream("partial", 32'b10011, 5, 2'd0, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_a.o_match_cnt !== 8'd0 || bus_a.o_f !== 1'b0 || bus_b.o_cnt_sat !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got cnt=%0d f=%b expected 0/0", bus_a.o_match_cnt, bus_a.o_f);
    end
    #1 rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 2'd0, 1'b0, f);
    checks++;
    if (f !== 1'b0) begin
      errors++; $display("FAIL after_rst o_f got %b expected 0", f);
    end
  endtask

  task automatic test_saturation();
    bit f;
    do_reset(); idle(2'd2);
    run_stream("sat", 32'b1001100110011001100110, 22, 2'd2,
               (32'd1 << 5) | (32'd1 << 9) | (32'd1 << 13) | (32'd1 << 17) | (32'd1 << 21));
    idle(2'd2);
    check_cnt("sat_hold", 5, 3, 1'b1);
    step(1'b1, 1'b0, 2'd2, 1'b0, f);
    step(1'b1, 1'b1, 2'd2, 1'b0, f);
    step(1'b1, 1'b1, 2'd2, 1'b0, f);
    step(1'b1, 1'b0, 2'd2, 1'b1, f);
    checks++;
    if (f !== 1'b1) begin
      errors++; $display("FAIL clr_match o_f got %b expected 1", f);
    end
    idle(2'd2);
    check_cnt("clr_prio", 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] mode;
    bit f;
    do_reset();
    mode = 2'd0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      step($urandom_range(0, 3) != 0, 1'($urandom), mode, $urandom_range(0, 59) == 0, f);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 2'd0, 1'b0);
    model_reset();
    test_reset();
    test_framed();
    test_modes();
    test_misalign();
    test_gaps();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
